// File: rtl/nway_cache_pkg.sv
// Shared types and address helpers for the N-way set-associative write-back cache.
// Address layout (word address): {tag, index, offset}.
package nway_cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WB,
    ST_FILL,
    ST_RESP
  } state_t;

  function automatic int off_w_f(input int words);
    return $clog2(words);
  endfunction

  function automatic int idx_w_f(input int nsets);
    return $clog2(nsets);
  endfunction

  function automatic int tag_w_f(input int add_w, input int nsets, input int words);
    return add_w - $clog2(nsets) - $clog2(words);
  endfunction

  function automatic logic [31:0] addr_off(input logic [31:0] addr, input int off_w);
    return addr & ((32'd1 << off_w) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_idx(input logic [31:0] addr, input int off_w,
                                           input int idx_w);
    return (addr >> off_w) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int off_w,
                                           input int idx_w);
    return addr >> (off_w + idx_w);
  endfunction

  function automatic logic [31:0] make_addr(input logic [31:0] tag, input logic [31:0] idx,
                                            input logic [31:0] off, input int off_w,
                                            input int idx_w);
    return (tag << (off_w + idx_w)) | (idx << off_w) | off;
  endfunction

endpackage

// File: rtl/nway_cache_lru.sv
// True-LRU age update and victim selection for one set (combinational).
// Age 0 is most recently used, NWAYS-1 least recently used.
module nway_cache_lru
  import nway_cache_pkg::*;
#(
  parameter int NWAYS = 4,
  parameter int AGE_W = 2
) (
  input  logic [NWAYS*AGE_W-1:0] ages_in,
  input  logic [NWAYS-1:0]       valid_in,
  input  logic [AGE_W-1:0]       touch_way,
  output logic [NWAYS*AGE_W-1:0] ages_out,
  output logic [AGE_W-1:0]       victim_way
);

  logic [AGE_W-1:0] touch_age;
  logic             found;

  always_comb begin
    touch_age = ages_in[touch_way*AGE_W +: AGE_W];
    ages_out  = ages_in;
    for (int w = 0; w < NWAYS; w++) begin
      if (AGE_W'(w) == touch_way) begin
        ages_out[w*AGE_W +: AGE_W] = '0;
      end else if (ages_in[w*AGE_W +: AGE_W] < touch_age) begin
        ages_out[w*AGE_W +: AGE_W] = ages_in[w*AGE_W +: AGE_W] + AGE_W'(1);
      end
    end
  end

  // Invalid ways are used lowest-first before any valid line is evicted.
  always_comb begin
    found      = 1'b0;
    victim_way = '0;
    for (int w = 0; w < NWAYS; w++) begin
      if (!found && !valid_in[w]) begin
        victim_way = AGE_W'(w);
        found      = 1'b1;
      end
    end
    if (!found) begin
      for (int w = 0; w < NWAYS; w++) begin
        if (ages_in[w*AGE_W +: AGE_W] == AGE_W'(NWAYS - 1)) victim_way = AGE_W'(w);
      end
    end
  end

endmodule

// File: rtl/nway_cache.sv
// N-way set-associative write-back/write-allocate cache with multi-word blocks.
// Optional NWAY_CACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module nway_cache
  import nway_cache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADD_WIDTH  = 12,
  parameter int NWAYS      = 4,
  parameter int NSETS      = 16,
  parameter int WORDS      = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADD_WIDTH-1:0]  cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ready,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  m_req,
  output logic                  m_we,
  output logic [ADD_WIDTH-1:0]  m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic                  m_ack,
  input  logic [DATA_WIDTH-1:0] m_rdata
`ifdef NWAY_CACHE_STATS_EN
  ,
  output logic [15:0]           hit_count,
  output logic [15:0]           miss_count
`endif
);

  localparam int OFF_W = off_w_f(WORDS);
  localparam int IDX_W = idx_w_f(NSETS);
  localparam int TAG_W = tag_w_f(ADD_WIDTH, NSETS, WORDS);
  localparam int OFFS  = (OFF_W > 0) ? OFF_W : 1;
  localparam int AGE_W = $clog2(NWAYS);
  localparam int LINES = NWAYS * NSETS;

  state_t                  state, state_n;
  logic                    req_we;
  logic [ADD_WIDTH-1:0]    req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [AGE_W-1:0]        victim_q, victim_n;
  logic [OFFS-1:0]         beat_q, beat_n, beat_nx;

  logic [DATA_WIDTH-1:0]   data_mem  [LINES*WORDS];
  logic [TAG_W-1:0]        tag_mem   [LINES];
  logic [NWAYS-1:0]        valid_mem [NSETS];
  logic [NWAYS-1:0]        dirty_mem [NSETS];
  logic [NWAYS*AGE_W-1:0]  age_mem   [NSETS];

  logic [ADD_WIDTH-1:0]    look_addr;
  logic [IDX_W-1:0]        set_c;
  logic [TAG_W-1:0]        tag_c;
  logic [OFFS-1:0]         off_c;
  logic                    hit;
  logic [AGE_W-1:0]        hit_way, lru_victim, touch_way;
  logic [NWAYS*AGE_W-1:0]  ages_touched;

  logic                    m_req_n, m_we_n, cpu_ready_n;
  logic [ADD_WIDTH-1:0]    m_addr_n;
  logic [DATA_WIDTH-1:0]   m_wdata_n, cpu_rdata_n;
  logic                    latch, age_we, hit_store, fill_we, fill_done;

  function automatic int lidx(input logic [AGE_W-1:0] w, input logic [IDX_W-1:0] s);
    return int'(w) * NSETS + int'(s);
  endfunction

  function automatic int widx(input logic [AGE_W-1:0] w, input logic [IDX_W-1:0] s,
                              input logic [OFFS-1:0] o);
    return (int'(w) * NSETS + int'(s)) * WORDS + int'(o);
  endfunction

  // The lookup uses the live request in IDLE, the latched one during a miss.
  assign look_addr = (state == ST_IDLE) ? cpu_addr : req_addr;
  assign set_c     = IDX_W'(addr_idx(32'(look_addr), OFF_W, IDX_W));
  assign tag_c     = TAG_W'(addr_tag(32'(look_addr), OFF_W, IDX_W));
  assign off_c     = OFFS'(addr_off(32'(look_addr), OFF_W));
  assign touch_way = (state == ST_IDLE) ? hit_way : victim_q;
  assign beat_nx   = beat_q + OFFS'(1);

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NWAYS; w++) begin
      if (!hit && valid_mem[set_c][w] && tag_mem[lidx(AGE_W'(w), set_c)] == tag_c) begin
        hit     = 1'b1;
        hit_way = AGE_W'(w);
      end
    end
  end

  nway_cache_lru #(
    .NWAYS (NWAYS),
    .AGE_W (AGE_W)
  ) u_lru (
    .ages_in    (age_mem[set_c]),
    .valid_in   (valid_mem[set_c]),
    .touch_way  (touch_way),
    .ages_out   (ages_touched),
    .victim_way (lru_victim)
  );

  always_comb begin
    state_n     = state;
    victim_n    = victim_q;
    beat_n      = beat_q;
    m_req_n     = m_req;
    m_we_n      = m_we;
    m_addr_n    = m_addr;
    m_wdata_n   = m_wdata;
    cpu_ready_n = 1'b0;
    cpu_rdata_n = cpu_rdata;
    latch       = 1'b0;
    age_we      = 1'b0;
    hit_store   = 1'b0;
    fill_we     = 1'b0;
    fill_done   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cpu_req) begin
          latch = 1'b1;
          if (hit) begin
            age_we      = 1'b1;
            hit_store   = cpu_we;
            cpu_ready_n = 1'b1;
            cpu_rdata_n = cpu_we ? '0 : data_mem[widx(hit_way, set_c, off_c)];
            state_n     = ST_RESP;
          end else begin
            victim_n = lru_victim;
            beat_n   = '0;
            m_req_n  = 1'b1;
            if (valid_mem[set_c][lru_victim] && dirty_mem[set_c][lru_victim]) begin
              m_we_n    = 1'b1;
              m_addr_n  = ADD_WIDTH'(make_addr(32'(tag_mem[lidx(lru_victim, set_c)]),
                                               32'(set_c), 32'd0, OFF_W, IDX_W));
              m_wdata_n = data_mem[widx(lru_victim, set_c, '0)];
              state_n   = ST_WB;
            end else begin
              m_we_n    = 1'b0;
              m_addr_n  = ADD_WIDTH'(make_addr(32'(tag_c), 32'(set_c), 32'd0, OFF_W, IDX_W));
              m_wdata_n = '0;
              state_n   = ST_FILL;
            end
          end
        end
      end
      ST_WB: begin
        if (m_ack) begin
          if (beat_q == OFFS'(WORDS - 1)) begin
            beat_n    = '0;
            m_we_n    = 1'b0;
            m_addr_n  = ADD_WIDTH'(make_addr(32'(tag_c), 32'(set_c), 32'd0, OFF_W, IDX_W));
            m_wdata_n = '0;
            state_n   = ST_FILL;
          end else begin
            beat_n    = beat_nx;
            m_addr_n  = ADD_WIDTH'(make_addr(32'(tag_mem[lidx(victim_q, set_c)]),
                                             32'(set_c), 32'(beat_nx), OFF_W, IDX_W));
            m_wdata_n = data_mem[widx(victim_q, set_c, beat_nx)];
          end
        end
      end
      ST_FILL: begin
        if (m_ack) begin
          fill_we = 1'b1;
          if (beat_q == OFFS'(WORDS - 1)) begin
            // The requested word may be arriving on this very beat.
            fill_done   = 1'b1;
            age_we      = 1'b1;
            m_req_n     = 1'b0;
            m_we_n      = 1'b0;
            m_addr_n    = '0;
            cpu_ready_n = 1'b1;
            cpu_rdata_n = req_we ? '0 :
                          (off_c == beat_q) ? m_rdata : data_mem[widx(victim_q, set_c, off_c)];
            state_n     = ST_RESP;
          end else begin
            beat_n   = beat_nx;
            m_addr_n = ADD_WIDTH'(make_addr(32'(tag_c), 32'(set_c), 32'(beat_nx),
                                            OFF_W, IDX_W));
          end
        end
      end
      ST_RESP: begin
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      victim_q  <= '0;
      beat_q    <= '0;
      m_req     <= 1'b0;
      m_we      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      cpu_ready <= 1'b0;
      cpu_rdata <= '0;
      for (int s = 0; s < NSETS; s++) begin
        valid_mem[s] <= '0;
        dirty_mem[s] <= '0;
        for (int w = 0; w < NWAYS; w++) age_mem[s][w*AGE_W +: AGE_W] <= AGE_W'(w);
      end
    end else begin
      state     <= state_n;
      victim_q  <= victim_n;
      beat_q    <= beat_n;
      m_req     <= m_req_n;
      m_we      <= m_we_n;
      m_addr    <= m_addr_n;
      m_wdata   <= m_wdata_n;
      cpu_ready <= cpu_ready_n;
      cpu_rdata <= cpu_rdata_n;
      if (age_we) age_mem[set_c] <= ages_touched;
      if (hit_store) dirty_mem[set_c][hit_way] <= 1'b1;
      if (fill_done) begin
        valid_mem[set_c][victim_q] <= 1'b1;
        dirty_mem[set_c][victim_q] <= req_we;
      end
    end
  end

  // Data, tag and latched request carry no reset; validity gates their use.
  always_ff @(posedge clock) begin
    if (latch) begin
      req_we    <= cpu_we;
      req_addr  <= cpu_addr;
      req_wdata <= cpu_wdata;
    end
    if (hit_store) data_mem[widx(hit_way, set_c, off_c)] <= cpu_wdata;
    if (fill_we) data_mem[widx(victim_q, set_c, beat_q)] <= m_rdata;
    if (fill_done) begin
      tag_mem[lidx(victim_q, set_c)] <= tag_c;
      if (req_we) data_mem[widx(victim_q, set_c, off_c)] <= req_wdata;
    end
  end

`ifdef NWAY_CACHE_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == ST_IDLE && cpu_req) begin
      if (hit) begin
        if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      end else begin
        if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_nway_cache.sv
// Directed bench for nway_cache: recency-list cache model plus word-addressed memory,
// checking every memory beat and every response against the model.
module tb_nway_cache;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [11:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        m_req, m_we;
  logic [11:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ack;
  logic [31:0] m_rdata;
`ifdef NWAY_CACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  nway_cache #(
    .DATA_WIDTH (32),
    .ADD_WIDTH  (12),
    .NWAYS      (4),
    .NSETS      (16),
    .WORDS      (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ready  (cpu_ready),
    .cpu_rdata  (cpu_rdata),
    .m_req      (m_req),
    .m_we       (m_we),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_ack      (m_ack),
    .m_rdata    (m_rdata)
`ifdef NWAY_CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          we;
    logic [11:0] addr;
    logic [31:0] data;
  } beat_t;

  logic [31:0] backing [4096];
  logic [31:0] ref_mem [4096];
  int          lru_q [16][$];
  bit          dirty_blk [1024];
  beat_t       exp_q [$];
  logic [31:0] exp_rd;
  bit          resp_pending;
  int          ack_delay;
  int          stall;
  int          checks, errors;
  int          model_hits, model_misses;

  assign m_rdata = backing[m_addr];

  function automatic void check(input bit ok, input string name, input logic [31:0] act,
                                input logic [31:0] expv);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endfunction

  // Memory responder: ack after ack_delay stall cycles per beat.
  always @(negedge clock) begin
    if (m_req && stall < ack_delay) begin
      m_ack = 1'b0;
      stall++;
    end else if (m_req) begin
      m_ack = 1'b1;
      stall = 0;
    end else begin
      m_ack = 1'b0;
      stall = 0;
    end
  end

  always @(posedge clock) begin
    if (m_req && m_ack) begin
      if (m_we) backing[m_addr] = m_wdata;
      if (exp_q.size() > 0) exp_q.delete(0);
    end
  end

  // Compare process: beats against the expected burst, responses against the model.
  always @(negedge clock) begin
    if (!reset) begin
      if (m_req) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_beat", 32'(m_addr), 32'h0);
        end else begin
          check(m_we == exp_q[0].we, "beat_we", 32'(m_we), 32'(exp_q[0].we));
          check(m_addr == exp_q[0].addr, "beat_addr", 32'(m_addr), 32'(exp_q[0].addr));
          if (exp_q[0].we) check(m_wdata == exp_q[0].data, "beat_wdata", m_wdata, exp_q[0].data);
        end
      end
      if (cpu_ready) begin
        check(resp_pending, "unexpected_ready", 32'(cpu_ready), 32'h0);
        if (resp_pending) check(cpu_rdata == exp_rd, "cpu_rdata", cpu_rdata, exp_rd);
        resp_pending = 1'b0;
      end
    end
  end

  task automatic model_access(input bit we, input logic [11:0] addr, input logic [31:0] wd,
                              output bit hit);
    int    blk, s, pos, ev;
    beat_t b;
    blk = int'(addr) >> 2;
    s   = blk % 16;
    pos = -1;
    for (int i = 0; i < lru_q[s].size(); i++) if (lru_q[s][i] == blk) pos = i;
    if (pos >= 0) begin
      hit = 1'b1;
      model_hits++;
      lru_q[s].delete(pos);
      lru_q[s].push_front(blk);
    end else begin
      hit = 1'b0;
      model_misses++;
      if (lru_q[s].size() == 4) begin
        ev = lru_q[s].pop_back();
        if (dirty_blk[ev]) begin
          for (int k = 0; k < 4; k++) begin
            b.we = 1'b1; b.addr = 12'(ev * 4 + k); b.data = ref_mem[ev * 4 + k];
            exp_q.push_back(b);
          end
        end
        dirty_blk[ev] = 1'b0;
      end
      for (int k = 0; k < 4; k++) begin
        b.we = 1'b0; b.addr = 12'(blk * 4 + k); b.data = 32'h0;
        exp_q.push_back(b);
      end
      lru_q[s].push_front(blk);
      dirty_blk[blk] = 1'b0;
    end
    if (we) begin
      ref_mem[addr]  = wd;
      dirty_blk[blk] = 1'b1;
      exp_rd         = 32'h0;
    end else begin
      exp_rd = ref_mem[addr];
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    resp_pending = 1'b0;
    for (int s = 0; s < 16; s++) lru_q[s].delete();
    for (int i = 0; i < 1024; i++) dirty_blk[i] = 1'b0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = backing[i];
    model_hits   = 0;
    model_misses = 0;
  endtask

  task automatic do_req(input bit we, input logic [11:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd);
    int lat, nb, exp_lat;
    bit h, got;
    model_access(we, addr, wd, h);
    nb = exp_q.size();
    @(negedge clock);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    resp_pending = 1'b1;
    lat = 0;
    got = 1'b0;
    while (lat < 500 && !got) begin
      @(posedge clock);
      lat++;
      #1;
      if (cpu_ready) got = 1'b1;
    end
    rd      = cpu_rdata;
    cpu_req = 1'b0;
    check(got, "ready_timeout", 32'(lat), 32'h0);
    exp_lat = h ? 1 : 1 + nb * (ack_delay + 1);
    check(lat == exp_lat, "latency", 32'(lat), 32'(exp_lat));
    check(exp_q.size() == 0, "burst_complete", 32'(exp_q.size()), 32'h0);
    @(posedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    bit          h;
    bit          tw [12];
    logic [11:0] ta [12];
    logic [31:0] td [12];

    checks = 0; errors = 0; stall = 0; ack_delay = 0;
    m_ack = 1'b0; resp_pending = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    for (int i = 0; i < 4096; i++) backing[i] = 32'h1000 + i;
    model_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check(cpu_ready == 1'b0, "rst_cpu_ready", 32'(cpu_ready), 32'h0);
    check(cpu_rdata == 32'h0, "rst_cpu_rdata", cpu_rdata, 32'h0);
    check(m_req == 1'b0, "rst_m_req", 32'(m_req), 32'h0);
    check(m_we == 1'b0, "rst_m_we", 32'(m_we), 32'h0);
    check(m_addr == 12'h0, "rst_m_addr", 32'(m_addr), 32'h0);
    check(m_wdata == 32'h0, "rst_m_wdata", m_wdata, 32'h0);
    reset = 1'b0;

    // Cold miss then hit in the same block.
    do_req(1'b0, 12'h040, 32'h0, rd);
    check(rd == 32'h0000_1040, "lit_load_040", rd, 32'h0000_1040);
    do_req(1'b0, 12'h041, 32'h0, rd);
    check(rd == 32'h0000_1041, "lit_hit_041", rd, 32'h0000_1041);

    // Store miss allocates, then load hits the stored word.
    do_req(1'b1, 12'h055, 32'h0000_DEAD, rd);
    do_req(1'b0, 12'h055, 32'h0, rd);
    check(rd == 32'h0000_DEAD, "lit_load_055", rd, 32'h0000_DEAD);

    // Fill set 0, re-touch 0x040, fifth tag evicts the dirty 0x000 block.
    do_req(1'b1, 12'h001, 32'hBEEF_0001, rd);
    do_req(1'b0, 12'h080, 32'h0, rd);
    do_req(1'b0, 12'h0C0, 32'h0, rd);
    do_req(1'b0, 12'h041, 32'h0, rd);
    do_req(1'b0, 12'h100, 32'h0, rd);
    check(backing[1] == 32'hBEEF_0001, "lit_wb_001", backing[1], 32'hBEEF_0001);
    check(backing[0] == 32'h0000_1000, "lit_wb_000", backing[0], 32'h0000_1000);
    do_req(1'b0, 12'h001, 32'h0, rd);
    check(rd == 32'hBEEF_0001, "lit_reload_001", rd, 32'hBEEF_0001);

    // Slow memory: three stall cycles per beat.
    ack_delay = 3;
    do_req(1'b0, 12'h3A7, 32'h0, rd);
    check(rd == 32'h0000_13A7, "lit_slow_3A7", rd, 32'h0000_13A7);

    // Mixed loads/stores churning set 1 with one stall per beat.
    ack_delay = 1;
    tw = '{1, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0};
    ta = '{12'h004, 12'h045, 12'h086, 12'h0C7, 12'h004, 12'h105,
           12'h146, 12'h086, 12'h044, 12'h005, 12'h187, 12'h106};
    td = '{32'hA000_0004, 32'h0, 32'hA000_0086, 32'h0, 32'h0, 32'hA000_0105,
           32'h0, 32'h0, 32'hA000_0044, 32'h0, 32'h0, 32'h0};
    for (int i = 0; i < 12; i++) do_req(tw[i], ta[i], td[i], rd);

    // Reset in the middle of a fill burst.
    ack_delay = 0;
    model_access(1'b0, 12'h123, 32'h0, h);
    @(negedge clock);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h123; resp_pending = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check(m_req == 1'b1, "pre_abort_m_req", 32'(m_req), 32'h1);
    #1;
    reset = 1'b1;
    #1;
    check(m_req == 1'b0, "abort_m_req", 32'(m_req), 32'h0);
    check(cpu_ready == 1'b0, "abort_cpu_ready", 32'(cpu_ready), 32'h0);
    cpu_req = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Everything misses again; dirty 0x055 was discarded by reset.
    do_req(1'b0, 12'h123, 32'h0, rd);
    check(rd == 32'h0000_1123, "lit_after_abort_123", rd, 32'h0000_1123);
    do_req(1'b0, 12'h055, 32'h0, rd);
    check(rd == 32'h0000_1055, "lit_discard_055", rd, 32'h0000_1055);
    do_req(1'b0, 12'h124, 32'h0, rd);
    do_req(1'b0, 12'h122, 32'h0, rd);
    do_req(1'b0, 12'h056, 32'h0, rd);
    check(rd == 32'h0000_1056, "lit_hit_056", rd, 32'h0000_1056);
`ifdef NWAY_CACHE_STATS_EN
    check(hit_count == 16'd2, "hit_count", 32'(hit_count), 32'd2);
    check(miss_count == 16'd3, "miss_count", 32'(miss_count), 32'd3);
    check(32'(hit_count) == 32'(model_hits), "hit_count_model", 32'(hit_count), 32'(model_hits));
`endif

    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
